ext_int_controller: RTL

Fixed-priority controller that collects one-cycle interrupt request pulses from the bank of external interrupt pin handlers, latches them as pending, masks them, and presents one vector at a time to the CPU core over a request/acknowledge/done handshake. It sits between the per-pin handlers and the core's trap logic. It also owns the pending and in-service status the core reads back.

---
 rtl/ext_int_ctrl_pkg.sv | 13 +
 rtl/int_priority_encoder.sv | 24 ++
 rtl/ext_int_controller.sv | 83 ++++++++
 3 files changed

// File: rtl/ext_int_ctrl_pkg.sv
// ext_int_controller shared types.
// FSM state encoding and default source count.
package ext_int_ctrl_pkg;

   localparam int NUM_SOURCES_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } int_state_t;

endpackage

// File: rtl/int_priority_encoder.sv
// Lowest-index-first priority encoder.
// Bit 0 has the highest priority.
module int_priority_encoder #(
   parameter int N        = 8,
   parameter int VECTOR_W = $clog2(N)
) (
   input  logic [N-1:0]        req,
   output logic [VECTOR_W-1:0] idx,
   output logic                valid
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = VECTOR_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ext_int_controller.sv
// Fixed-priority external interrupt controller.
// Latches pulses as pending and hands one vector at a time to the core.
module ext_int_controller
   import ext_int_ctrl_pkg::*;
#(
   parameter int NUM_SOURCES = NUM_SOURCES_DEFAULT,
   parameter int VECTOR_W    = $clog2(NUM_SOURCES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_SOURCES-1:0] irq_pulse,
   input  logic [NUM_SOURCES-1:0] int_mask,
   input  logic                   global_enable,
   input  logic [NUM_SOURCES-1:0] pending_clear,
   output logic                   int_req,
   output logic [VECTOR_W-1:0]    int_vector,
   input  logic                   int_ack,
   input  logic                   int_done,
   output logic [NUM_SOURCES-1:0] pending,
   output logic [NUM_SOURCES-1:0] in_service
);

   int_state_t state;

   logic [NUM_SOURCES-1:0] eligible;
   logic [NUM_SOURCES-1:0] vec_onehot;
   logic [NUM_SOURCES-1:0] clr_mask;
   logic [VECTOR_W-1:0]    win_idx;
   logic                   win_valid;
   logic                   ack_fire;

   assign eligible   = pending & int_mask;
   assign vec_onehot = NUM_SOURCES'(1) << int_vector;
   assign ack_fire   = (state == REQUEST) && int_ack;
   assign clr_mask   = pending_clear
                     | (ack_fire ? vec_onehot : '0);

   int_priority_encoder #(
      .N        (NUM_SOURCES),
      .VECTOR_W (VECTOR_W)
   ) u_enc (
      .req   (eligible),
      .idx   (win_idx),
      .valid (win_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         in_service <= '0;
         int_req    <= 1'b0;
         int_vector <= '0;
      end else begin
         // A new pulse outranks any clear of the same bit.
         pending <= (pending & ~clr_mask) | irq_pulse;
         unique case (state)
            IDLE: begin
               if (global_enable && win_valid) begin
                  int_vector <= win_idx;
                  int_req    <= 1'b1;
                  state      <= REQUEST;
               end
            end
            REQUEST: begin
               if (int_ack) begin
                  int_req    <= 1'b0;
                  in_service <= vec_onehot;
                  state      <= SERVICE;
               end
            end
            SERVICE: begin
               if (int_done) begin
                  in_service <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
